ahb_master_req_ctrl: RTL
========================

Name: ahb_master_req_ctrl

Overview:
- Master-side request/burst controller; the initiator counterpart of the per-slave AHB arbiters.
- Accepts one burst command from a local master and decodes the target slave from the address MSBs.
- Raises hreq to that slave's arbiter, drives beats as hgrant qualifies them, and flags the final beat on hlast so the arbiter can release.
- One instance sits between each local master and the interconnect's per-slave arbiters.

Parameters:
- SLAVE_NUM, 4, number of slaves/arbiters reachable; width of hreq/hlast/hgrant.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; address increment per beat = DATA_WIDTH/8.
- LEN_WIDTH, 4, burst length field; beats = cmd_len+1 (1..16).
- TIMEOUT_CYCLES, 64, grant-wait limit (only with AHB_MASTER_TIMEOUT_EN).

Ports:
- hclk  in  1  clock.
- hreset  in  1  reset: one clock; reset is asynchronous and active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid & ready.
- cmd_addr  in  ADDR_WIDTH  start address; slave index = cmd_addr[ADDR_WIDTH-1 -: $clog2(SLAVE_NUM)].
- cmd_write  in  1  1 = write burst.
- cmd_len  in  LEN_WIDTH  beats-1.
- wdata  in  DATA_WIDTH  current write beat data.
- wdata_ack  out  1  pulse: write beat consumed.
- rdata  out  DATA_WIDTH  read beat data.
- rdata_valid  out  1  pulse: rdata valid.
- done  out  1  one-cycle pulse at burst end.
- err  out  1  qualifies done: decode error or timeout.
- hreq  out  SLAVE_NUM  one-hot request to target arbiter.
- hlast  out  SLAVE_NUM  one-hot last-beat flag.
- hgrant  in  SLAVE_NUM  grant from arbiters (already gated by ~hwait).
- hwait  in  1  selected slave wait.
- haddr  out  ADDR_WIDTH  beat address.
- htrans  out  2  IDLE/NONSEQ/SEQ (BUSY never driven).
- hwrite  out  1  direction.
- hwdata  out  DATA_WIDTH  = wdata while in BURST.
- hrdata  in  DATA_WIDTH  read data.

Behaviour:
- Reset (async, hreset=1): state IDLE; hreq, hlast, done, err, wdata_ack, rdata_valid, hwrite = 0; htrans = IDLE; haddr = 0; rdata = 0; cmd_ready = 0 while hreset is high.
- Beat completes in a cycle where hgrant[tgt]=1 && hwait=0.
- States:
  - IDLE: cmd_ready=1. On accept, latch addr, len, write, tgt.
    - tgt >= SLAVE_NUM → ERR.
    - Otherwise → REQ; hreq[tgt] is registered high the next cycle (1-cycle latency from accept).
  - REQ: hreq[tgt]=1; htrans=IDLE; wait for the first completing beat. That beat is beat 0, htrans=NONSEQ → BURST (or RESP if len=0).
  - BURST: htrans=SEQ; each completing beat: haddr += DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH, no 1KB check); beat counter decrements.
    - hgrant low mid-burst: stall; hold haddr/htrans/hlast and keep hreq.
  - hlast[tgt]=1 combinationally while remaining count==0 (including len=0 in REQ).
  - On last beat completion: hreq and hlast clear at the next edge → RESP.
  - RESP: done=1, err=0 for one cycle → IDLE. cmd_ready=0, so back-to-back commands have a 1-cycle gap.
  - ERR: done=1, err=1 for one cycle, no bus activity → IDLE.
- Data signals:
  - Write: wdata_ack=1 in the cycle a write beat completes; wdata must change for the next beat after that edge.
  - Read: rdata registered from hrdata on beat completion; rdata_valid pulses the following cycle.
- hgrant on a non-target index: ignored.
- Reset mid-burst: immediate return to IDLE; hreq and hlast drop asynchronously.

Optional Feature:
- AHB_MASTER_TIMEOUT_EN defined:
  - Counter runs in REQ and clears on the first grant.
  - When it reaches TIMEOUT_CYCLES: drop hreq → ERR (done with err=1).
  - No timeout in BURST.
- Undefined: REQ waits indefinitely; no counter logic is synthesized.

Decomposition:
- AHB_package holds:
  - htrans_t enum (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11).
  - master FSM state enum (IDLE, REQ, BURST, RESP, ERR).
- Sub-module ahb_master_slave_decode (combinational): address → one-hot slave select plus decode-error flag; reused by other masters.

Test Plan:
- Write, cmd_addr=0x4000_0010, len=3, SLAVE_NUM=4, hgrant[1] high from 2 cycles after hreq → hreq=4'b0010; haddr 0x..10,14,18,1C with NONSEQ,SEQ,SEQ,SEQ; 4 wdata_ack; hlast[1] on 4th beat only; done after.
- Single read, len=0, slave 3, hrdata=0xDEADBEEF → hlast[3] high in REQ; rdata=0xDEADBEEF with rdata_valid 1 cycle after grant; done, err=0.
- Burst len=7 with hgrant dropped for 3 cycles after beat 2 and hwait high 2 cycles → exactly 8 beats; address held during stalls; hreq never drops.
- SLAVE_NUM=3, addr top bits=2'b11 → no hreq; done & err one cycle after accept.
- hreset asserted during beat 2 of a 4-beat burst → hreq/hlast 0 immediately; next command proceeds normally from IDLE.
- With AHB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=64, hgrant never asserted → hreq held 64 cycles then dropped; done & err=1.

Source files
------------

// File: rtl/ahb_master_req_ctrl_pkg.sv
// Shared types for the AHB master request/burst controller and its slave decoder.
package ahb_master_req_ctrl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BURST = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } mst_state_t;

  // Width of the slave index field; at least one bit so a single-slave build still elaborates.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_master_req_ctrl_slave_decode.sv
// Address-to-slave decoder: one-hot select from the address MSBs plus a decode-error flag
// for indices beyond SLAVE_NUM. Purely combinational so other masters can reuse it.
module ahb_master_slave_decode
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int SLAVE_NUM  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [SLAVE_NUM-1:0]  sel,
  output logic                  dec_err
);

  localparam int SEL_W = sel_width(SLAVE_NUM);

  logic [SEL_W-1:0] idx_s;
  logic             unused_addr_s;

  assign idx_s         = addr[ADDR_WIDTH-1 -: SEL_W];
  assign unused_addr_s = ^addr[ADDR_WIDTH-SEL_W-1:0];

  // Index to one-hot, flagging indices that have no arbiter behind them.
  always_comb begin
    sel     = {SLAVE_NUM{1'b0}};
    dec_err = 1'b0;
    if (32'(idx_s) >= 32'(SLAVE_NUM)) begin
      dec_err = 1'b1;
    end else begin
      sel = SLAVE_NUM'(1'b1) << idx_s;
    end
  end

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// Master-side AHB request/burst controller: takes one burst command, requests the decoded
// slave's arbiter and walks the beats as grants arrive. Optional grant timeout: AHB_MASTER_TIMEOUT_EN.
module ahb_master_req_ctrl
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int SLAVE_NUM      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic                  err,
  output logic [SLAVE_NUM-1:0]  hreq,
  output logic [SLAVE_NUM-1:0]  hlast,
  input  logic [SLAVE_NUM-1:0]  hgrant,
  input  logic                  hwait,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(DATA_WIDTH / 8);

  mst_state_t            state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LEN_WIDTH-1:0]  rem_r;
  logic                  write_r;
  logic [SLAVE_NUM-1:0]  tgt_r;
  logic                  cmd_ready_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  rdata_valid_r;
  logic [SLAVE_NUM-1:0]  dec_sel_s;
  logic                  dec_err_s;
  logic                  accept_s, grant_s, active_s, beat_s, last_s, timeout_s;
  htrans_t               htrans_s;

  ahb_master_slave_decode #(
    .SLAVE_NUM (SLAVE_NUM),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_decode (
    .addr   (cmd_addr),
    .sel    (dec_sel_s),
    .dec_err(dec_err_s)
  );

  assign accept_s = cmd_valid && cmd_ready_r;
  // Grants on indices other than the latched target are deliberately ignored.
  assign grant_s  = |(hgrant & tgt_r);
  assign active_s = (state_r == ST_REQ) || (state_r == ST_BURST);
  assign beat_s   = active_s && grant_s && !hwait;
  assign last_s   = (rem_r == {LEN_WIDTH{1'b0}});

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_r;

  assign timeout_s = (state_r == ST_REQ) && !grant_s && (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1));

  // Grant-wait counter: only runs while requesting, any target grant restarts it.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      tmo_r <= {TMO_W{1'b0}};
    end else if ((state_r == ST_REQ) && !grant_s) begin
      tmo_r <= tmo_r + TMO_W'(1);
    end else begin
      tmo_r <= {TMO_W{1'b0}};
    end
  end
`else
  logic [31:0] unused_tmo_s;

  assign timeout_s    = 1'b0;
  assign unused_tmo_s = 32'(TIMEOUT_CYCLES);
`endif

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = dec_err_s ? ST_ERR : ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (beat_s) begin
          state_nxt_s = last_s ? ST_RESP : ST_BURST;
        end else if (timeout_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_BURST: begin
        if (beat_s && last_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      ST_ERR:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, command acceptance and read-return registers.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_r       <= ST_IDLE;
      cmd_ready_r   <= 1'b0;
      rdata_r       <= {DATA_WIDTH{1'b0}};
      rdata_valid_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cmd_ready_r   <= (state_nxt_s == ST_IDLE);
      rdata_valid_r <= beat_s && !write_r;
      if (beat_s && !write_r) begin
        rdata_r <= hrdata;
      end
    end
  end

  // Burst context: latched at accept, advanced per completed beat; the last beat leaves it as is.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      addr_r  <= {ADDR_WIDTH{1'b0}};
      rem_r   <= {LEN_WIDTH{1'b0}};
      write_r <= 1'b0;
      tgt_r   <= {SLAVE_NUM{1'b0}};
    end else if (accept_s) begin
      addr_r  <= cmd_addr;
      rem_r   <= cmd_len;
      write_r <= cmd_write;
      tgt_r   <= dec_sel_s;
    end else if (beat_s && !last_s) begin
      addr_r <= addr_r + ADDR_INC;
      rem_r  <= rem_r - LEN_WIDTH'(1);
    end
  end

  // Transfer type: NONSEQ is only shown in REQ once the target grant is present.
  always_comb begin
    htrans_s = HTRANS_IDLE;
    case (state_r)
      ST_REQ: begin
        if (grant_s) begin
          htrans_s = HTRANS_NONSEQ;
        end else begin
          htrans_s = HTRANS_IDLE;
        end
      end
      ST_BURST: htrans_s = HTRANS_SEQ;
      default:  htrans_s = HTRANS_IDLE;
    endcase
  end

  assign cmd_ready   = cmd_ready_r;
  assign hreq        = active_s ? tgt_r : {SLAVE_NUM{1'b0}};
  assign hlast       = (active_s && last_s) ? tgt_r : {SLAVE_NUM{1'b0}};
  assign haddr       = addr_r;
  assign htrans      = htrans_s;
  assign hwrite      = active_s && write_r;
  assign hwdata      = active_s ? wdata : {DATA_WIDTH{1'b0}};
  assign wdata_ack   = beat_s && write_r;
  assign rdata       = rdata_r;
  assign rdata_valid = rdata_valid_r;
  assign done        = (state_r == ST_RESP) || (state_r == ST_ERR);
  assign err         = (state_r == ST_ERR);

endmodule
